// File: rtl/ifetch.sv
// Instruction fetch unit: reads up to four instruction bytes one at a time,
// assembles them left-aligned and hands the word to decode over valid/ready.
module ifetch #(
  parameter int              AW       = 16,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_in,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack,
  output logic [31:0]   ir_in,
  output logic [2:0]    ir_len,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [1:0]    dbg_state
);

  // Handshake: a word transfers on the rising edge where ir_valid & ir_ready;
  // ir_valid never drops and ir_in/ir_len/ir_pc never change until that edge.

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [2:0]    len_q, len_d;
  logic [31:0]   buf_q, buf_d;
  logic          stale_q, stale_d;
  logic [2:0]    cnt_inc;
  logic [2:0]    len_eff;

  function automatic logic [2:0] decode_len(input logic [7:0] op);
    if (op == 8'hF4)
      return 3'd1;
    else if (op[7:3] == 5'b10111 || op == 8'h81)
      return 3'd4;
    else
      return 3'd2;
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_pc_d = ir_pc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    buf_d   = buf_q;
    stale_d = stale_q;
    cnt_inc = cnt_q + 3'd1;
    len_eff = (cnt_q == 3'd0) ? decode_len(mem_rdata) : len_q;

    if (pc_load) begin
      pc_d    = pc_in;
      ir_pc_d = pc_in;
      cnt_d   = 3'd0;
      buf_d   = '0;
      // A request issued but not yet acked must be drained before refetching.
      stale_d = (state_q == S_REQ) || (state_q == S_WAIT && !mem_ack);
      if (stale_d)
        state_d = S_WAIT;
      else
        state_d = run ? S_REQ : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          buf_d   = '0;
          cnt_d   = 3'd0;
          ir_pc_d = pc_q;
          if (run)
            state_d = S_REQ;
        end
        S_REQ: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (mem_ack) begin
            if (stale_q) begin
              stale_d = 1'b0;
              state_d = run ? S_REQ : S_IDLE;
            end else begin
              case (cnt_q[1:0])
                2'd0:    buf_d[31:24] = mem_rdata;
                2'd1:    buf_d[23:16] = mem_rdata;
                2'd2:    buf_d[15:8]  = mem_rdata;
                default: buf_d[7:0]   = mem_rdata;
              endcase
              cnt_d = cnt_inc;
              pc_d  = pc_q + {{(AW-1){1'b0}}, 1'b1};
              len_d = len_eff;
              state_d = (cnt_inc == len_eff) ? S_HOLD : S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (ir_ready) begin
            ir_pc_d = pc_q;
            cnt_d   = 3'd0;
            buf_d   = '0;
            state_d = run ? S_REQ : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_pc_q <= RESET_PC;
      cnt_q   <= 3'd0;
      len_q   <= 3'd0;
      buf_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_pc_q <= ir_pc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      stale_q <= stale_d;
    end
  end

  assign mem_rd    = (state_q == S_REQ);
  assign mem_addr  = pc_q;
  assign ir_in     = buf_q;
  assign ir_len    = len_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = (state_q == S_HOLD);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: byte memory responder with programmable ack delay,
// hand-computed expected words, redirect/stale-ack, PC wrap and reset cases.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_in = '0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] ir_in;
  logic [2:0]  ir_len;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [0:65535];
  int          ack_dly = 0;
  logic        pend = 1'b0;
  int          dly_cnt = 0;
  logic [15:0] paddr = '0;
  logic [15:0] rd_log[$];
  logic [15:0] exp_q[$];

  ifetch #(.AW(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .run(run), .pc_load(pc_load), .pc_in(pc_in),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .ir_in(ir_in), .ir_len(ir_len), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory responder: sees the request on the REQ-cycle negedge and raises
  // mem_ack for one cycle after ack_dly further cycles.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (dly_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[paddr];
          pend      = 1'b0;
        end else begin
          dly_cnt = dly_cnt - 1;
        end
      end
      if (mem_rd) begin
        pend    = 1'b1;
        paddr   = mem_addr;
        dly_cnt = ack_dly;
        rd_log.push_back(mem_addr);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (ir_valid) break;
      @(negedge clk);
    end
    check_eq({tag, "_valid"}, ir_valid, 1'b1);
  endtask

  task automatic wait_rd(input logic [15:0] addr, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (mem_rd && mem_addr == addr) break;
      @(negedge clk);
    end
    check_eq("wait_rd", {mem_rd, mem_addr}, {1'b1, addr});
  endtask

  task automatic accept();
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] addr);
    pc_load = 1'b1;
    pc_in   = addr;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'hF4;
    mem[16'h0010] = 8'hB8; mem[16'h0011] = 8'h34;
    mem[16'h0012] = 8'h12; mem[16'h0013] = 8'h00;
    mem[16'h0020] = 8'hB8; mem[16'h0021] = 8'hB8;
    mem[16'h0022] = 8'hB8; mem[16'h0023] = 8'hB8;
    mem[16'h0040] = 8'hF4;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_mem_rd",   mem_rd,   1'b0);
    check_eq("rst_mem_addr", mem_addr, 16'h0000);
    check_eq("rst_ir_in",    ir_in,    32'h0);
    check_eq("rst_ir_len",   ir_len,   3'd0);
    check_eq("rst_ir_pc",    ir_pc,    16'h0000);
    check_eq("rst_ir_valid", ir_valid, 1'b0);
    rst = 1'b0;
    run = 1'b1;

    // Single-byte halt at 0
    @(negedge clk);
    check_eq("t1_rd",   {mem_rd, mem_addr}, {1'b1, 16'h0000});
    wait_valid("t1", 20);
    check_eq("t1_ir_in",  ir_in,  32'hF400_0000);
    check_eq("t1_ir_len", ir_len, 3'd1);
    check_eq("t1_ir_pc",  ir_pc,  16'h0000);
    accept();
    check_eq("t1_next_rd", {mem_rd, mem_addr}, {1'b1, 16'h0001});

    // Redirect to a 4-byte mov at 0x10 (issued while a request is in flight)
    redirect(16'h0010);
    wait_valid("t2", 40);
    check_eq("t2_ir_in",  ir_in,  32'hB834_1200);
    check_eq("t2_ir_len", ir_len, 3'd4);
    check_eq("t2_ir_pc",  ir_pc,  16'h0010);
    accept();
    check_eq("t2_next_rd", {mem_rd, mem_addr}, {1'b1, 16'h0014});

    // Two 2-byte instructions with consumer back-pressure
    mem[16'h0000] = 8'h75; mem[16'h0001] = 8'hFE;
    mem[16'h0002] = 8'h8B; mem[16'h0003] = 8'hC1;
    redirect(16'h0000);
    wait_valid("t3a", 40);
    check_eq("t3a_ir_in",  ir_in,  32'h75FE_0000);
    check_eq("t3a_ir_len", ir_len, 3'd2);
    check_eq("t3a_ir_pc",  ir_pc,  16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t3_hold_ir_in", ir_in, 32'h75FE_0000);
      check_eq("t3_hold_valid_rd", {ir_valid, mem_rd}, 2'b10);
    end
    accept();
    check_eq("t3_next_rd", {mem_rd, mem_addr}, {1'b1, 16'h0002});
    wait_valid("t3b", 40);
    check_eq("t3b_ir_in",  ir_in,  32'h8BC1_0000);
    check_eq("t3b_ir_len", ir_len, 3'd2);
    check_eq("t3b_ir_pc",  ir_pc,  16'h0002);

    // Redirect while waiting on a slow ack for byte 1 of a mov
    ack_dly = 3;
    redirect(16'h0020);
    wait_rd(16'h0021, 60);
    @(negedge clk);
    redirect(16'h0040);
    wait_valid("t4", 80);
    check_eq("t4_ir_in",  ir_in,  32'hF400_0000);
    check_eq("t4_ir_len", ir_len, 3'd1);
    check_eq("t4_ir_pc",  ir_pc,  16'h0040);
    accept();
    ack_dly = 0;

    // PC wrap across 0xFFFF
    mem[16'hFFFF] = 8'h70; mem[16'h0000] = 8'h05;
    redirect(16'hFFFF);
    rd_log.delete();
    exp_q = {16'hFFFF, 16'h0000};
    wait_valid("t5", 40);
    check_eq("t5_ir_in",  ir_in,  32'h7005_0000);
    check_eq("t5_ir_pc",  ir_pc,  16'hFFFF);
    check_eq("t5_nreads", rd_log.size(), exp_q.size());
    while (exp_q.size() > 0 && rd_log.size() > 0)
      check_eq("t5_rd_addr", rd_log.pop_front(), exp_q.pop_front());
    accept();
    check_eq("t5_next_rd", {mem_rd, mem_addr}, {1'b1, 16'h0001});

    // Reset while holding a valid word
    wait_valid("t6", 40);
    check_eq("t6_ir_in", ir_in, 32'hFE8B_0000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    check_eq("t6_ir_valid", ir_valid, 1'b0);
    check_eq("t6_ir_in",    ir_in,    32'h0);
    check_eq("t6_mem_addr", mem_addr, 16'h0000);
    check_eq("t6_mem_rd",   mem_rd,   1'b0);
    check_eq("t6_state",    dbg_state, 2'd0);
    repeat (3) @(negedge clk);
    check_eq("t6_idle_rd",  mem_rd,   1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch unit. Reads instruction bytes from byte-wide instruction memory at the PC and assembles them into the left-aligned 32-bit word consumed by the instruction register.
- Presents the word with a valid/ready handshake, then advances the PC past the instruction.
- Sits between instruction memory and the IR/decode stage.
- Supports PC redirect for branches; a redirect flushes any in-flight fetch.

Parameters:
AW, 16, instruction address / PC width in bits
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous active-high reset
run  in  1  fetch enable; 0 holds fetch in IDLE
pc_load  in  1  redirect strobe (branch taken)
pc_in  in  AW  redirect target
mem_rd  out  1  byte read request
mem_addr  out  AW  byte address of request
mem_rdata  in  8  read data, valid when mem_ack=1
mem_ack  in  1  read completion, one cycle per request
ir_in  out  32  assembled instruction; byte0 in [31:24], byte1 [23:16], byte2 [15:8], byte3 [7:0]; unused bytes zero
ir_len  out  3  instruction length in bytes, 1..4
ir_pc  out  AW  address of byte0
ir_valid  out  1  ir_in/ir_len/ir_pc valid
ir_ready  in  1  consumer accepts when ir_valid & ir_ready

Behaviour:
- Reset (rst=1 at a clk edge, including mid-fetch or while holding):
  - pc=RESET_PC, state IDLE.
  - mem_rd=0, mem_addr=RESET_PC.
  - ir_in=0, ir_len=0, ir_pc=RESET_PC, ir_valid=0.
  - Any outstanding memory request is abandoned; a late mem_ack is ignored.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - run=1 -> REQ.
  - Clear the assembly buffer and byte count cnt=0.
  - Latch ir_pc=pc.
- REQ:
  - Drive mem_rd=1 for exactly one cycle with mem_addr=pc.
  - Next state WAIT.
- WAIT:
  - mem_rd=0. Wait for mem_ack; there is no timeout.
  - On mem_ack: store mem_rdata into byte slot cnt, increment cnt and pc (pc wraps modulo 2^AW).
  - If cnt==0, also latch the length from the received byte.
  - If the new cnt equals the length -> HOLD, else -> REQ.
  - mem_ack in the same cycle as mem_rd is legal and is taken in WAIT on the next cycle. Memory holds mem_ack until that cycle.
- Length decode from byte0:
  - 8'hF4 (halt) -> 1.
  - 8'hB8..8'hBF (mov r, imm16) -> 4.
  - 8'h81 (alu r, imm16) -> 4.
  - 8'h70..8'h7F (Jcc sim8) -> 2.
  - 8'hEB (jmp sim8) -> 2.
  - All others -> 2.
- HOLD:
  - ir_valid=1. ir_in, ir_len and ir_pc are stable until accepted.
  - On ir_valid & ir_ready: ir_valid=0 next cycle, latch ir_pc=pc. Then go to REQ if run=1, else IDLE.
  - Back-to-back throughput is one instruction per (2·len+1) cycles when memory acks immediately.
- Redirect (pc_load=1, any non-reset state):
  - pc=pc_in, ir_valid=0, cnt=0, ir_pc=pc_in.
  - Next state REQ if run=1, else IDLE.
  - The buffer is cleared; the partial instruction is discarded.
  - Any mem_ack in the same or later cycle for the pre-redirect request is dropped. A single-bit flag marks the outstanding stale request, and the FSM waits in WAIT for its ack before issuing the new REQ.
  - pc_load coincident with handshake acceptance: the instruction counts as accepted and the redirect wins for the next PC.
- Priority: rst > pc_load > handshake/ack.
- run deasserted mid-instruction: the current instruction completes. run is sampled only in IDLE and on leaving HOLD.

Test Plan:
- Reset, run=1, memory at 0: F4 -> mem_rd at addr 0. After ack: ir_valid=1, ir_in=32'hF4000000, ir_len=1, ir_pc=0, next fetch addr 1.
- Bytes B8 34 12 00 at 0x10, redirect to 0x10, zero-wait ack -> ir_in=32'hB8341200, ir_len=4, ir_pc=0x10, pc=0x14.
- Stream 75 FE / 8B C1 with ir_ready=0 for 5 cycles -> ir_in=32'h75FE0000 held constant, no mem_rd issued. Second instruction 32'h8BC10000 with ir_pc=2 after ready.
- pc_load=1, pc_in=0x40 while waiting for byte 2 of a B8 instruction (ack delayed 3 cycles) -> stale ack dropped. Next valid instruction has ir_pc=0x40; no 0xB8 data appears.
- AW=16, pc=0xFFFF, 2-byte instruction -> second byte read from 0x0000, pc=0x0001 after.
- rst=1 while in HOLD with ir_valid=1 -> next cycle ir_valid=0, ir_in=0, mem_addr=RESET_PC, mem_rd=0.
